// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: waits for the start bit, shifts in a 48- or 136-bit
// response, checks framing bits and CRC7 (x^7+x^3+1), and holds results until re-armed.
module sd_cmd_resp_rx #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_en,
  input  logic         cmd_in,
  input  logic         start,
  input  logic         long_resp,
  input  logic         no_crc,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic         end_err,
  output logic         trans_err,
  output logic [5:0]   resp_index,
  output logic [127:0] resp
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECV,
    DONE
  } state_t;

  state_t state, state_next;

  logic [TW-1:0] idle_cnt;
  logic [7:0]    bit_cnt;
  logic [6:0]    crc;
  logic [126:0]  shreg;
  logic          long_q;
  logic          no_crc_q;

  logic          arm;
  logic          count_idle;
  logic          tmo;
  logic          take_start;
  logic          take_bit;
  logic          last_bit;
  logic          crc_en;
  logic [7:0]    frame_len;
  logic [7:0]    bit_idx;
  logic [127:0]  shreg_next;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic inv;
    inv = b ^ c[6];
    return {c[5:3], c[2] ^ inv, c[1:0], inv};
  endfunction

  // bit_cnt counts sampled frame bits, so the frame bit number of the bit being
  // sampled is (length - 1 - bit_cnt); the end bit is frame bit 0.
  assign frame_len  = long_q ? 8'd136 : 8'd48;
  assign bit_idx    = frame_len - 8'd1 - bit_cnt;
  assign shreg_next = {shreg, cmd_in};
  assign crc_en     = take_bit && (bit_idx >= 8'd8) && (bit_idx <= 8'd127);

  assign busy = (state == WAIT_START) || (state == RECV);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    count_idle = 1'b0;
    tmo        = 1'b0;
    take_start = 1'b0;
    take_bit   = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          arm        = 1'b1;
          state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (bit_en) begin
          if (!cmd_in) begin
            take_start = 1'b1;
            state_next = RECV;
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            tmo        = 1'b1;
            state_next = DONE;
          end else begin
            count_idle = 1'b1;
          end
        end
      end
      RECV: begin
        if (bit_en) begin
          take_bit = 1'b1;
          if (bit_idx == 8'd0) begin
            last_bit   = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt    <= '0;
      bit_cnt     <= '0;
      crc         <= '0;
      shreg       <= '0;
      long_q      <= 1'b0;
      no_crc_q    <= 1'b0;
      timeout_err <= 1'b0;
      crc_err     <= 1'b0;
      end_err     <= 1'b0;
      trans_err   <= 1'b0;
      resp_index  <= '0;
      resp        <= '0;
    end else begin
      if (arm) begin
        long_q      <= long_resp;
        no_crc_q    <= no_crc;
        idle_cnt    <= '0;
        bit_cnt     <= '0;
        crc         <= '0;
        shreg       <= '0;
        timeout_err <= 1'b0;
        crc_err     <= 1'b0;
        end_err     <= 1'b0;
        trans_err   <= 1'b0;
        resp_index  <= '0;
        resp        <= '0;
      end
      if (count_idle) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (tmo) begin
        timeout_err <= 1'b1;
      end
      // Only short responses include the start bit in the CRC.
      if (take_start) begin
        bit_cnt <= 8'd1;
        if (!long_q) begin
          crc <= crc7_step(crc, cmd_in);
        end
      end
      if (take_bit) begin
        bit_cnt <= bit_cnt + 8'd1;
        shreg   <= shreg_next[126:0];
        if (crc_en) begin
          crc <= crc7_step(crc, cmd_in);
        end
        if (bit_cnt == 8'd1) begin
          trans_err <= cmd_in;
        end
        if (last_bit) begin
          end_err <= !cmd_in;
          crc_err <= !no_crc_q && (crc != shreg[6:0]);
          if (long_q) begin
            resp       <= shreg_next;
            resp_index <= '0;
          end else begin
            resp       <= {88'b0, shreg_next[39:0]};
            resp_index <= shreg_next[45:40];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Randomised and directed bench for sd_cmd_resp_rx; expected results come from a
// transaction-level model using CRC7 long division.
module tb_sd_cmd_resp_rx;

  localparam int TMO   = 64;
  localparam int NEVER = 32'h7fff_ffff;

  logic         clk = 1'b0;
  logic         rst, bit_en, cmd_in, start, long_resp, no_crc;
  logic         busy, done, timeout_err, crc_err, end_err, trans_err;
  logic [5:0]   resp_index;
  logic [127:0] resp;

  always #5 clk = ~clk;

  sd_cmd_resp_rx #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .cmd_in(cmd_in), .start(start),
    .long_resp(long_resp), .no_crc(no_crc), .busy(busy), .done(done),
    .timeout_err(timeout_err), .crc_err(crc_err), .end_err(end_err),
    .trans_err(trans_err), .resp_index(resp_index), .resp(resp)
  );

  typedef struct packed {
    logic         tmo;
    logic         crc_e;
    logic         end_e;
    logic         trans_e;
    logic [5:0]   idx;
    logic [127:0] resp;
  } res_t;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 0;
  bit   t_active;
  int   t_start, t_done;
  res_t t_res, hold_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, over frame bits hi..lo.
  function automatic logic [6:0] crc7(input bit [135:0] f, input int hi, input int lo);
    bit m [0:143];
    int n;
    logic [6:0] c;
    n = hi - lo + 1;
    for (int k = 0; k < n + 7; k++) m[k] = (k < n) ? f[hi-k] : 1'b0;
    for (int k = 0; k < n; k++) begin
      if (m[k]) begin
        m[k]   = ~m[k];
        m[k+4] = ~m[k+4];
        m[k+7] = ~m[k+7];
      end
    end
    for (int j = 0; j < 7; j++) c[6-j] = m[n+j];
    return c;
  endfunction

  function automatic res_t model(input bit [135:0] f, input bit lng, input bit nc, input bit to);
    res_t r;
    r = '0;
    if (to) begin
      r.tmo = 1'b1;
      return r;
    end
    if (lng) begin
      r.resp    = f[127:0];
      r.trans_e = f[134];
      r.crc_e   = !nc && (crc7(f, 127, 8) != f[7:1]);
    end else begin
      r.idx     = f[45:40];
      r.resp    = {88'b0, f[39:0]};
      r.trans_e = f[46];
      r.crc_e   = !nc && (crc7(f, 47, 8) != f[7:1]);
    end
    r.end_e = !f[0];
    return r;
  endfunction

  function automatic bit [135:0] mk_short(input bit [39:0] body, input bit [6:0] c, input bit e);
    bit [135:0] f;
    f = '0;
    f[47:8] = body;
    f[7:1]  = c;
    f[0]    = e;
    return f;
  endfunction

  function automatic bit [135:0] mk_long(input bit [119:0] data, input bit [5:0] rsv);
    bit [135:0] f;
    f = '0;
    f[133:128] = rsv;
    f[127:8]   = data;
    f[7:1]     = crc7(f, 127, 8);
    f[0]       = 1'b1;
    return f;
  endfunction

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    bit   eb, ed;
    res_t er;
    if (chk_en) begin
      eb = t_active && (cyc >= t_start) && (cyc < t_done);
      ed = t_active && (cyc == t_done);
      er = (t_active && cyc >= t_done) ? t_res : hold_res;
      chk("busy", 128'(busy), 128'(eb));
      chk("done", 128'(done), 128'(ed));
      if (!eb) begin
        chk("timeout_err", 128'(timeout_err), 128'(er.tmo));
        chk("crc_err", 128'(crc_err), 128'(er.crc_e));
        chk("end_err", 128'(end_err), 128'(er.end_e));
        chk("trans_err", 128'(trans_err), 128'(er.trans_e));
        chk("resp_index", 128'(resp_index), 128'(er.idx));
        chk("resp", resp, er.resp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int g);
    repeat (g) tick();
  endtask

  function automatic int pick_gap(input int gm);
    return (gm < 0) ? int'($urandom_range(0, 3)) : gm;
  endfunction

  task automatic strobe(input logic b);
    cmd_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    cmd_in = 1'($urandom);
  endtask

  task automatic arm(input bit lng, input bit nc, input bit coinc, input res_t e);
    start     = 1'b1;
    long_resp = lng;
    no_crc    = nc;
    if (coinc) begin
      bit_en = 1'b1;
      cmd_in = 1'b0;
    end
    if (t_active) hold_res = t_res;
    t_res    = e;
    t_start  = cyc + 1;
    t_done   = NEVER;
    t_active = 1'b1;
    tick();
    start     = 1'b0;
    bit_en    = 1'b0;
    long_resp = 1'($urandom);
    no_crc    = 1'($urandom);
  endtask

  task automatic run(input bit [135:0] f, input bit lng, input bit nc, input int idle,
                     input int gm, input bit coinc, input bit poke, input int rst_at);
    res_t e;
    int   len;
    len = lng ? 136 : 48;
    e   = model(f, lng, nc, idle >= TMO);
    arm(lng, nc, coinc, e);
    idle_gap(pick_gap(gm));
    if (idle >= TMO) begin
      for (int i = 0; i < TMO; i++) begin
        strobe(1'b1);
        if (i == TMO - 1) t_done = cyc;
        idle_gap(pick_gap(gm));
      end
    end else begin
      for (int i = 0; i < idle; i++) begin
        strobe(1'b1);
        idle_gap(pick_gap(gm));
      end
      for (int b = len - 1; b >= 0; b--) begin
        if (rst_at >= 0 && (len - 1 - b) == rst_at) begin
          rst = 1'b1;
          tick();
          rst      = 1'b0;
          hold_res = '0;
          t_active = 1'b0;
          idle_gap(3);
          return;
        end
        if (poke && b == len - 20) begin
          start     = 1'b1;
          long_resp = !lng;
          no_crc    = !nc;
          tick();
          start = 1'b0;
        end
        strobe(f[b]);
        if (b == 0) t_done = cyc;
        idle_gap(pick_gap(gm));
      end
    end
    idle_gap(2);
  endtask

  initial begin
    bit [135:0] zf, ff, r3, f;
    res_t       m;
    bit         lng, nc;
    int         kind, idle, len, p;

    rst = 1'b1; bit_en = 1'b0; cmd_in = 1'b1; start = 1'b0;
    long_resp = 1'b0; no_crc = 1'b0;
    t_active = 1'b0; t_start = 0; t_done = NEVER; t_res = '0; hold_res = '0;
    tick();
    chk_en = 1'b1;
    idle_gap(2);
    rst = 1'b0;
    idle_gap(2);

    // Model pins against known CMD-line CRC values.
    zf = mk_short(40'h00_00000000, 7'h00, 1'b1);
    ff = mk_short(40'h00_00000001, 7'h00, 1'b1);
    r3 = mk_short(40'h3F_80FF8000, 7'h7F, 1'b1);
    chk("pin_crc_zero", 128'(crc7(zf, 47, 8)), 128'(7'h00));
    chk("pin_crc_cmd0", 128'(crc7(mk_short(40'h40_00000000, 7'h0, 1'b1), 47, 8)), 128'(7'h4A));
    chk("pin_crc_cmd8", 128'(crc7(mk_short(40'h48_000001AA, 7'h0, 1'b1), 47, 8)), 128'(7'h43));
    chk("pin_crc_cmd17", 128'(crc7(mk_short(40'h51_00000000, 7'h0, 1'b1), 47, 8)), 128'(7'h2A));
    m = model(ff, 1'b0, 1'b0, 1'b0);
    chk("pin_flip_crc_err", 128'(m.crc_e), 128'(1));
    chk("pin_flip_arg", 128'(m.resp[39:8]), 128'(32'h1));
    m = model(r3, 1'b0, 1'b0, 1'b0);
    chk("pin_r3_crc_err", 128'(m.crc_e), 128'(1));
    m = model(r3, 1'b0, 1'b1, 1'b0);
    chk("pin_r3_nocrc_idx", 128'({m.crc_e, m.idx}), 128'({1'b0, 6'h3F}));

    // Directed cases.
    run(zf, 0, 0, 5, 0, 0, 0, -1);
    run(zf, 0, 0, 5, 3, 0, 0, -1);
    run(ff, 0, 0, 2, 0, 0, 0, -1);
    run(r3, 0, 1, 1, 0, 0, 0, -1);
    run(r3, 0, 0, 1, 1, 0, 0, -1);
    run(mk_short(40'h00_00000000, 7'h00, 1'b0), 0, 0, 0, 0, 0, 0, -1);
    run(mk_short(40'h40_00000000, 7'h00, 1'b1), 0, 0, 0, 0, 0, 0, -1);
    run(zf, 0, 0, TMO, 0, 0, 0, -1);
    f = mk_short(40'h11_DEADBEEF, 7'h0, 1'b1);
    f[7:1] = crc7(f, 47, 8);
    run(f, 0, 0, TMO - 1, 0, 0, 0, -1);
    f = mk_long({$urandom, $urandom, $urandom, 24'($urandom)}, 6'h3F);
    run(f, 1, 0, 3, 0, 0, 0, -1);
    run(f, 1, 0, 3, 1, 0, 0, 70);
    f = mk_short(40'h08_000001AA, 7'h0, 1'b1);
    f[7:1] = crc7(f, 47, 8);
    run(f, 0, 0, 2, 0, 0, 0, -1);
    run(f, 0, 0, 0, 0, 1, 0, -1);
    run(f, 0, 0, 1, 0, 0, 1, -1);
    run(mk_long({$urandom, $urandom, $urandom, 24'($urandom)}, 6'h15), 1, 1, 0, 0, 0, 1, -1);

    // Randomised transactions.
    for (int t = 0; t < 30; t++) begin
      lng  = 1'($urandom);
      nc   = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 7);
      len  = lng ? 136 : 48;
      if (lng) begin
        f = mk_long({$urandom, $urandom, $urandom, 24'($urandom)}, 6'($urandom));
      end else begin
        f = mk_short({2'b00, 6'($urandom), $urandom}, 7'h0, 1'b1);
        f[7:1] = crc7(f, 47, 8);
      end
      if (kind == 0) begin
        p = $urandom_range(1, len - 2);
        f[p] = ~f[p];
      end
      if (kind == 1) f[0] = 1'b0;
      if (kind == 2) f[len-2] = 1'b1;
      if (kind == 3) idle = TMO + $urandom_range(0, 5);
      else if ($urandom_range(0, 9) == 0) idle = TMO - 1;
      else idle = $urandom_range(0, 8);
      run(f, lng, nc, idle, -1, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
